// File: rtl/set_host_seq.sv
// ============================================================================
// set_host_seq
// ----------------------------------------------------------------------------
// Initiator-side driver for the circle-set candidate-count engine. It walks a
// synchronous test-vector ROM and issues each vector to the engine. Each ROM
// word holds central (24b), radius (12b), mode (2b) and an expected count (8b).
// The engine's candidate result is compared against the expected count, and
// the result is tallied as a pass or a fail. An engine that never returns
// valid is caught by a per-vector timeout.
//
// Parameters
//   NUM_VEC  vectors per run (1 .. 2**AW)
//   AW       vector ROM address width
//   TIMEOUT  WAIT cycles before a vector is declared failed (1 .. 65535)
//   GAP      idle cycles between a result and the next fetch (0 .. 15)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   i_start        begin a run (honoured only in IDLE / DONE)
//   o_vec_addr     vector ROM address
//   i_vec_data     ROM word, valid one cycle after o_vec_addr
//                  [45:22] central, [21:10] radius, [9:8] mode, [7:0] expected
//   o_en           one-cycle command strobe to the engine
//   o_central      command operand, held from ISSUE until result/timeout
//   o_radius       command operand, held like o_central
//   o_mode         command operand, held like o_central
//   i_busy         engine busy; no strobe is issued while high
//   i_valid        engine result strobe
//   i_candidate    engine result, sampled when i_valid=1 in WAIT
//   o_done         high while in DONE
//   o_pass_cnt     vectors that matched
//   o_fail_cnt     vectors that mismatched or timed out
//   o_timeout_seen sticky: some vector timed out during this run
//   o_first_fail   index of the first failing vector (valid when fail_cnt!=0)
// ============================================================================
module set_host_seq #(
    parameter int NUM_VEC = 64,
    parameter int AW      = 6,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic [AW-1:0] o_vec_addr,
    input  logic [45:0]   i_vec_data,
    output logic          o_en,
    output logic [23:0]   o_central,
    output logic [11:0]   o_radius,
    output logic [1:0]    o_mode,
    input  logic          i_busy,
    input  logic          i_valid,
    input  logic [7:0]    i_candidate,
    output logic          o_done,
    output logic [AW:0]   o_pass_cnt,
    output logic [AW:0]   o_fail_cnt,
    output logic          o_timeout_seen,
    output logic [AW-1:0] o_first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_idx;
    logic [15:0]   r_waitCnt;
    logic [3:0]    r_gapCnt;
    logic [7:0]    r_exp;
    logic [7:0]    r_cand;
    logic          r_miss;
    logic          r_failSeen;
    logic [23:0]   r_central;
    logic [11:0]   r_radius;
    logic [1:0]    r_mode;
    logic          r_done;
    logic [AW:0]   r_passCnt;
    logic [AW:0]   r_failCnt;
    logic          r_timeoutSeen;
    logic [AW-1:0] r_firstFail;

    logic          w_lastVec;
    logic          w_mismatch;

    assign w_lastVec  = (r_idx == AW'(NUM_VEC - 1));
    // A timed-out vector counts as a fail even though no candidate was captured.
    assign w_mismatch = r_miss || (r_cand != r_exp);

    // The ROM address simply follows the vector index; idx only moves on the
    // way back to FETCH, so the address is stable through FETCH and LOAD.
    assign o_vec_addr     = r_idx;
    // The strobe is decoded from state and busy so it lands in the very cycle
    // the engine is seen idle, rather than one cycle late.
    assign o_en           = (r_state == S_ISSUE) && !i_busy;
    assign o_central      = r_central;
    assign o_radius       = r_radius;
    assign o_mode         = r_mode;
    assign o_done         = r_done;
    assign o_pass_cnt     = r_passCnt;
    assign o_fail_cnt     = r_failCnt;
    assign o_timeout_seen = r_timeoutSeen;
    assign o_first_fail   = r_firstFail;

    // Main sequencer: fetch a vector, present it, wait for the engine, score
    // the result, then pause GAP cycles before the next vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_waitCnt     <= '0;
            r_gapCnt      <= '0;
            r_exp         <= '0;
            r_cand        <= '0;
            r_miss        <= 1'b0;
            r_failSeen    <= 1'b0;
            r_central     <= '0;
            r_radius      <= '0;
            r_mode        <= '0;
            r_done        <= 1'b0;
            r_passCnt     <= '0;
            r_failCnt     <= '0;
            r_timeoutSeen <= 1'b0;
            r_firstFail   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A restart from DONE clears exactly like a start from IDLE.
                    if (i_start) begin
                        r_passCnt     <= '0;
                        r_failCnt     <= '0;
                        r_timeoutSeen <= 1'b0;
                        r_firstFail   <= '0;
                        r_failSeen    <= 1'b0;
                        r_idx         <= '0;
                        r_done        <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_central <= i_vec_data[45:22];
                    r_radius  <= i_vec_data[21:10];
                    r_mode    <= i_vec_data[9:8];
                    r_exp     <= i_vec_data[7:0];
                    r_state   <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (!i_busy) begin
                        r_waitCnt <= '0;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (i_valid) begin
                        r_cand    <= i_candidate;
                        r_miss    <= 1'b0;
                        r_waitCnt <= '0;
                        r_state   <= S_CHECK;
                    end else if (r_waitCnt == 16'(TIMEOUT - 1)) begin
                        r_failCnt     <= r_failCnt + (AW+1)'(1);
                        r_timeoutSeen <= 1'b1;
                        r_miss        <= 1'b1;
                        r_waitCnt     <= '0;
                        r_state       <= S_CHECK;
                    end else begin
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end

                S_CHECK: begin
                    // Timeouts were already counted in WAIT; only score real results.
                    if (!r_miss) begin
                        if (r_cand == r_exp) begin
                            r_passCnt <= r_passCnt + (AW+1)'(1);
                        end else begin
                            r_failCnt <= r_failCnt + (AW+1)'(1);
                        end
                    end
                    if (w_mismatch && !r_failSeen) begin
                        r_firstFail <= r_idx;
                        r_failSeen  <= 1'b1;
                    end
                    r_miss <= 1'b0;
                    if (w_lastVec) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx    <= r_idx + AW'(1);
                        r_gapCnt <= '0;
                        r_state  <= (GAP == 0) ? S_FETCH : S_GAP;
                    end
                end

                S_GAP: begin
                    if (r_gapCnt == 4'(GAP - 1)) begin
                        r_gapCnt <= '0;
                        r_state  <= S_FETCH;
                    end else begin
                        r_gapCnt <= r_gapCnt + 4'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
